// File: rtl/rrs_decimate.sv
// Keeps 1 of D samples, rounds (half-up) and saturates to width_H+out_W bits, buffers in a depth-entry FIFO.
// Latency: kept sample strobed in cycle k is visible on data_o in cycle k+2 when the FIFO is empty.
// Backpressure: valid/ready on the output; no stall toward the filter, so a full FIFO drops and sets sticky ovf.
module rrs_decimate #(
    parameter int width_H = 5,
    parameter int width_W = 20,
    parameter int out_W   = 11,
    parameter int D       = 4,
    parameter int log_D   = 2,
    parameter int depth   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_i_en,
    input  logic [width_H+width_W-1:0]   data_i,
    input  logic                         data_o_rdy,
    output logic                         data_o_en,
    output logic [width_H+out_W-1:0]     data_o,
    output logic                         ovf
);

    localparam int IW = width_H + width_W;
    localparam int OW = width_H + out_W;
    localparam int S  = width_W - out_W;
    localparam int AW = (depth > 2) ? $clog2(depth) : 1;

    localparam logic [log_D-1:0] CNT_LAST = log_D'(D - 1);
    localparam logic [IW:0]      HALF     = (IW + 1)'(1) << (S - 1);
    localparam logic [AW:0]      FILL_MAX = (AW + 1)'(depth);

    logic [log_D-1:0] cnt_q, cnt_d;
    logic             rv_q, rv_d;
    logic [OW-1:0]    rq_q, rq_d;
    logic [OW-1:0]    mem_q [depth];
    logic [OW-1:0]    mem_d [depth];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             ovf_q, ovf_d;

    logic             keep, push, pop, drop, full, empty;
    logic [IW:0]      sum;
    logic [OW:0]      rnd;
    logic [OW-1:0]    sat;

    // Phase counter and requantizer: one extra sign bit absorbs the rounding carry, then clamp.
    always_comb begin
        keep  = data_i_en && (cnt_q == '0);
        cnt_d = cnt_q;
        if (data_i_en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + log_D'(1);
        end
        sum = {data_i[IW-1], data_i} + HALF;
        rnd = sum[IW:S];
        if (rnd[OW] != rnd[OW-1]) begin
            sat = rnd[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
            sat = rnd[OW-1:0];
        end
        rv_d = keep;
        rq_d = keep ? sat : rq_q;
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when the head is popped the same edge.
    always_comb begin
        empty  = (fill_q == '0);
        full   = (fill_q == FILL_MAX);
        pop    = !empty && data_o_rdy;
        push   = rv_q && (!full || pop);
        drop   = rv_q && full && !pop;
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (push) begin
            mem_d[wr_q] = rq_q;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - (AW + 1)'(1);
        end
        ovf_d = ovf_q | drop;
    end

    // Control state with synchronous reset; storage array needs no reset since empty masks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rv_q   <= 1'b0;
            rq_q   <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rv_q   <= rv_d;
            rq_q   <= rq_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_o_en = !empty;
    assign data_o    = empty ? '0 : mem_q[rd_q];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rrs_decimate.sv
// Directed bench for rrs_decimate: one D=4 instance and one D=1 instance driven by shared inputs.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Expected values are hand-derived constants or simple index formulas.
module tb_rrs_decimate;

    logic        clk;
    logic        rst;
    logic        data_i_en;
    logic [24:0] data_i;
    logic        data_o_rdy;
    logic        en4, ovf4, en1, ovf1;
    logic [15:0] do4, do1;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [24:0] din;
        logic [15:0] dout;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] popped [$];
    int          kin, kk;
    logic        exp_en;
    logic [15:0] exp_d;

    rrs_decimate #(.width_H(5), .width_W(20), .out_W(11), .D(4), .log_D(2), .depth(4)) u_d4 (
        .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i),
        .data_o_rdy(data_o_rdy), .data_o_en(en4), .data_o(do4), .ovf(ovf4)
    );

    rrs_decimate #(.width_H(5), .width_W(20), .out_W(11), .D(1), .log_D(1), .depth(4)) u_d1 (
        .clk(clk), .rst(rst), .data_i_en(data_i_en), .data_i(data_i),
        .data_o_rdy(data_o_rdy), .data_o_en(en1), .data_o(do1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        data_i_en = 1'b0;
        step();
        rst       = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        data_i_en  = 1'b0;
        data_i     = '0;
        data_o_rdy = 1'b0;

        vecs[0] = '{25'h0000FF, 16'h0000};
        vecs[1] = '{25'h000100, 16'h0001};
        vecs[2] = '{25'h1FFFF00, 16'h0000};
        vecs[3] = '{25'h1FFFEFF, 16'hFFFF};
        vecs[4] = '{25'h0FFFFFF, 16'h7FFF};
        vecs[5] = '{25'h1000000, 16'h8000};
        vecs[6] = '{25'h0FFFE00, 16'h7FFF};

        @(negedge clk);

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            data_i_en  = 1'($urandom);
            data_i     = 25'($urandom);
            data_o_rdy = 1'($urandom);
            step();
            chk("rst_en4", en4, 0);
            chk("rst_do4", do4, 0);
            chk("rst_ovf4", ovf4, 0);
            chk("rst_en1", en1, 0);
            chk("rst_ovf1", ovf1, 0);
        end

        // First strobed sample after release is kept, visible two cycles later.
        rst = 1'b0; data_o_rdy = 1'b1; data_i_en = 1'b1; data_i = 25'(3 * 512);
        step();
        chk("first_lat", en4, 0);
        data_i_en = 1'b0;
        step();
        chk("first_en", en4, 1);
        chk("first_dat", do4, 16'h0003);
        step();
        chk("first_drain", en4, 0);

        // Decimation, gapless (p=1) and with 3 idle cycles between strobes (p=4).
        for (int p = 1; p <= 4; p += 3) begin
            do_reset();
            data_o_rdy = 1'b1;
            for (int j = 1; j <= 8 * p + 3; j++) begin
                kin       = (j - 1) / p;
                data_i_en = ((j - 1) % p == 0) && (kin < 8);
                data_i    = 25'(kin * 512);
                step();
                exp_en = 1'b0;
                exp_d  = '0;
                if (j >= 2 && (j - 2) % p == 0) begin
                    kk = (j - 2) / p;
                    if (kk < 8 && kk % 4 == 0) begin
                        exp_en = 1'b1;
                        exp_d  = 16'(kk);
                    end
                end
                chk($sformatf("decim_en_p%0d_c%0d", p, j), en4, exp_en);
                chk($sformatf("decim_dat_p%0d_c%0d", p, j), do4, exp_d);
            end
        end

        // Rounding and saturation vectors on the D=1 instance.
        do_reset();
        data_o_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_i_en = 1'b1;
            data_i    = vecs[i].din;
            step();
            chk($sformatf("rnd%0d_lat", i), en1, 0);
            data_i_en = 1'b0;
            step();
            chk($sformatf("rnd%0d_en", i), en1, 1);
            chk($sformatf("rnd%0d_dat", i), do1, vecs[i].dout);
            step();
        end
        chk("rnd_ovf", ovf1, 0);

        // Throughput: continuous strobes, continuous ready, no bubbles.
        do_reset();
        data_o_rdy = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            data_i_en = (j <= 5);
            data_i    = 25'(j * 512);
            step();
            exp_en = (j >= 2 && j <= 6);
            exp_d  = exp_en ? 16'(j - 1) : 16'h0000;
            chk($sformatf("thru_en_c%0d", j), en1, exp_en);
            chk($sformatf("thru_dat_c%0d", j), do1, exp_d);
        end

        // Overflow: ready low, 6 samples, 5th and 6th dropped; head stable while stalled.
        do_reset();
        data_o_rdy = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            data_i_en = (j <= 6);
            data_i    = 25'(j * 512);
            step();
            chk($sformatf("ovf_flag_c%0d", j), ovf1, (j >= 6));
            chk($sformatf("ovf_en_c%0d", j), en1, (j >= 2));
            chk($sformatf("ovf_head_c%0d", j), do1, (j >= 2) ? 16'h0001 : 16'h0000);
        end
        data_i_en  = 1'b0;
        data_o_rdy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("drain_en%0d", i), en1, (i <= 4));
            chk($sformatf("drain_dat%0d", i), do1, (i <= 4) ? 16'(i) : 16'h0000);
            step();
        end
        step();
        chk("ovf_sticky", ovf1, 1);

        // Full FIFO with simultaneous push and pop: nothing lost, no overflow.
        do_reset();
        popped.delete();
        for (int j = 1; j <= 15; j++) begin
            data_i_en  = (j <= 7);
            data_i     = 25'(j * 512);
            data_o_rdy = (j >= 6);
            if (en1 && data_o_rdy) popped.push_back(do1);
            step();
        end
        chk("pp_count", popped.size(), 7);
        for (int i = 0; i < popped.size() && i < 7; i++) begin
            chk($sformatf("pp_dat%0d", i), popped[i], 16'(i + 1));
        end
        chk("pp_ovf", ovf1, 0);

        // Reset mid-run: D=4 with cnt=2 and two entries; D=1 already overflowed.
        do_reset();
        data_o_rdy = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            data_i_en = 1'b1;
            data_i    = 25'((j - 1) * 512);
            step();
        end
        data_i_en = 1'b0;
        step();
        chk("mid_pre_en4", en4, 1);
        chk("mid_pre_ovf1", ovf1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_en4", en4, 0);
        chk("mid_do4", do4, 0);
        chk("mid_en1", en1, 0);
        chk("mid_ovf1", ovf1, 0);
        data_i_en = 1'b1;
        data_i    = 25'(7 * 512);
        step();
        data_i_en = 1'b0;
        chk("mid_lat", en4, 0);
        step();
        chk("mid_keep_en", en4, 1);
        chk("mid_keep_dat", do4, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
